// File: rtl/sram2axi_master_if.sv
// AXI3 channel bundle between the SRAM-style master bridge and its slave.
// Master drives AW/W/AR and the B/R readies; the slave drives the rest.
interface sram2axi_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
) ();
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [3:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic [ID_WIDTH-1:0]   AWID;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  WLAST;
  logic [ID_WIDTH-1:0]   WID;
  logic                  WVALID;
  logic                  WREADY;

  logic [ID_WIDTH-1:0]   BID;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [3:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic [ID_WIDTH-1:0]   ARID;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic [ID_WIDTH-1:0]   RID;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WID, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RLAST, RID, RVALID,
    output RREADY
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WID, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RLAST, RID, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/sram2axi_master.sv
// SRAM-style request bus (req/addr_ok/data_ok) to AXI3 single-beat master.
// Only one transaction is ever outstanding, so BID/RID are not inspected.
module sram2axi_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned MASTER_ID  = 0
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [STRB_WIDTH-1:0] cpu_wmask,
  output logic                  cpu_addr_ok,
  output logic                  cpu_data_ok,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_err,
  sram2axi_master_if.master     axi
);

  localparam logic [2:0]          AxSize = 3'($clog2(STRB_WIDTH));
  localparam logic [ID_WIDTH-1:0] AxId   = ID_WIDTH'(MASTER_ID);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAwW, StB, StDone} state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wmask_q;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, rready_q, bready_q;
  logic                  err_d;
  logic                  accept;
  logic                  r_last_beat;

  assign accept      = (state_q == StIdle) && cpu_req;
  assign cpu_addr_ok = (state_q == StIdle);
  assign r_last_beat = (state_q == StR) && axi.RVALID && axi.RLAST;

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: if (cpu_req) state_d = cpu_we ? StAwW : StAr;
      StAr:   if (axi.ARREADY) state_d = StR;
      StR: begin
        if (axi.RVALID && axi.RLAST) begin
          state_d = StDone;
          err_d   = |axi.RRESP;
        end
      end
      StAwW: begin
        // A channel counts as done if it already handshook or does so now.
        if ((!awvalid_q || axi.AWREADY) && (!wvalid_q || axi.WREADY)) state_d = StB;
      end
      StB: begin
        if (axi.BVALID) begin
          state_d = StDone;
          err_d   = |axi.BRESP;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    if (accept && cpu_we) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
    end else begin
      if (awvalid_q && axi.AWREADY) awvalid_d = 1'b0;
      if (wvalid_q && axi.WREADY)   wvalid_d  = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      bready_q    <= 1'b0;
      cpu_data_ok <= 1'b0;
      cpu_err     <= 1'b0;
      cpu_rdata   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
    end else begin
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= (state_d == StAr);
      rready_q    <= (state_d == StR);
      bready_q    <= (state_d == StB);
      cpu_data_ok <= (state_d == StDone);
      cpu_err     <= err_d;
      if (accept) begin
        addr_q  <= cpu_address;
        wdata_q <= cpu_wdata;
        wmask_q <= cpu_wmask;
      end
      if (r_last_beat) cpu_rdata <= axi.RDATA;
    end
  end

  assign axi.AWADDR  = addr_q;
  assign axi.AWLEN   = 4'd0;
  assign axi.AWSIZE  = AxSize;
  assign axi.AWBURST = 2'b01;
  assign axi.AWID    = AxId;
  assign axi.AWVALID = awvalid_q;

  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = wmask_q;
  assign axi.WLAST   = wvalid_q;
  assign axi.WID     = AxId;
  assign axi.WVALID  = wvalid_q;

  assign axi.BREADY  = bready_q;

  assign axi.ARADDR  = addr_q;
  assign axi.ARLEN   = 4'd0;
  assign axi.ARSIZE  = AxSize;
  assign axi.ARBURST = 2'b01;
  assign axi.ARID    = AxId;
  assign axi.ARVALID = arvalid_q;

  assign axi.RREADY  = rready_q;

  logic unused_ok;
  assign unused_ok = ^{axi.BID, axi.RID};

endmodule

// File: tb/tb_sram2axi_master.sv
// Directed bench for sram2axi_master: the bench plays the AXI slave and the CPU,
// expected values are hand-computed per cycle.
module tb_sram2axi_master;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 4;

  logic          ACLK;
  logic          ARESETn;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_address;
  logic [DW-1:0] cpu_wdata;
  logic [3:0]    cpu_wmask;
  logic          cpu_addr_ok;
  logic          cpu_data_ok;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_err;

  int n_checks = 0;
  int n_errors = 0;

  sram2axi_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) axi ();

  sram2axi_master #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ID_WIDTH  (IW),
    .MASTER_ID (0)
  ) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_address(cpu_address),
    .cpu_wdata  (cpu_wdata),
    .cpu_wmask  (cpu_wmask),
    .cpu_addr_ok(cpu_addr_ok),
    .cpu_data_ok(cpu_data_ok),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .axi        (axi.master)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic slave_idle();
    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.BVALID  = 1'b0;
    axi.BRESP   = 2'b00;
    axi.BID     = '0;
    axi.ARREADY = 1'b0;
    axi.RVALID  = 1'b0;
    axi.RLAST   = 1'b0;
    axi.RRESP   = 2'b00;
    axi.RDATA   = '0;
    axi.RID     = '0;
  endtask

  task automatic cpu_issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask);
    cpu_req     = 1'b1;
    cpu_we      = we;
    cpu_address = addr;
    cpu_wdata   = data;
    cpu_wmask   = mask;
  endtask

  initial begin
    ARESETn     = 1'b0;
    cpu_req     = 1'b0;
    cpu_we      = 1'b0;
    cpu_address = '0;
    cpu_wdata   = '0;
    cpu_wmask   = '0;
    slave_idle();
    tick();
    tick();
    check("rst_arvalid", axi.ARVALID, 0);
    check("rst_awvalid", axi.AWVALID, 0);
    check("rst_wvalid", axi.WVALID, 0);
    check("rst_bready", axi.BREADY, 0);
    check("rst_rready", axi.RREADY, 0);
    check("rst_data_ok", cpu_data_ok, 0);
    check("rst_rdata", cpu_rdata, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick();
    check("idle_addr_ok", cpu_addr_ok, 1);

    // Read 0x10, zero-wait slave
    cpu_issue(1'b0, 32'h10, 32'h0, 4'hf);
    tick();  // T+1
    cpu_req = 1'b0;
    check("rd_arvalid", axi.ARVALID, 1);
    check("rd_araddr", axi.ARADDR, 32'h10);
    check("rd_arlen", axi.ARLEN, 0);
    check("rd_arsize", axi.ARSIZE, 2);
    check("rd_arburst", axi.ARBURST, 1);
    check("rd_arid", axi.ARID, 0);
    check("rd_addr_ok_busy", cpu_addr_ok, 0);
    axi.ARREADY = 1'b1;
    tick();  // T+2
    axi.ARREADY = 1'b0;
    check("rd_arvalid_drop", axi.ARVALID, 0);
    check("rd_rready", axi.RREADY, 1);
    check("rd_no_early_ok", cpu_data_ok, 0);
    axi.RVALID = 1'b1;
    axi.RLAST  = 1'b1;
    axi.RDATA  = 32'hDEADBEEF;
    tick();  // T+3
    slave_idle();
    check("rd_data_ok", cpu_data_ok, 1);
    check("rd_rdata", cpu_rdata, 32'hDEADBEEF);
    check("rd_err", cpu_err, 0);
    check("rd_done_addr_ok", cpu_addr_ok, 0);
    check("rd_rready_drop", axi.RREADY, 0);
    tick();  // T+4
    check("rd_pulse_one", cpu_data_ok, 0);
    check("rd_back_idle", cpu_addr_ok, 1);

    // Write 0x12345678 mask 3 to 0x20, W handshakes before AW
    cpu_issue(1'b1, 32'h20, 32'h12345678, 4'b0011);
    tick();  // T+1
    cpu_req = 1'b0;
    check("wr_awvalid", axi.AWVALID, 1);
    check("wr_wvalid", axi.WVALID, 1);
    check("wr_awaddr", axi.AWADDR, 32'h20);
    check("wr_wdata", axi.WDATA, 32'h12345678);
    check("wr_wstrb", axi.WSTRB, 4'h3);
    check("wr_wlast", axi.WLAST, 1);
    check("wr_awsize", axi.AWSIZE, 2);
    check("wr_awlen", axi.AWLEN, 0);
    axi.WREADY = 1'b1;
    tick();  // T+2
    axi.WREADY = 1'b0;
    check("wr_wvalid_drop", axi.WVALID, 0);
    check("wr_awvalid_hold", axi.AWVALID, 1);
    check("wr_bready_early", axi.BREADY, 0);
    tick();  // T+3
    check("wr_awvalid_hold2", axi.AWVALID, 1);
    check("wr_awaddr_stable", axi.AWADDR, 32'h20);
    axi.AWREADY = 1'b1;
    tick();  // T+4
    axi.AWREADY = 1'b0;
    check("wr_awvalid_drop", axi.AWVALID, 0);
    check("wr_bready", axi.BREADY, 1);
    tick();  // T+5
    check("wr_bready_hold", axi.BREADY, 1);
    check("wr_no_early_ok", cpu_data_ok, 0);
    axi.BVALID = 1'b1;
    tick();  // T+6
    slave_idle();
    check("wr_data_ok", cpu_data_ok, 1);
    check("wr_err", cpu_err, 0);
    check("wr_rdata_kept", cpu_rdata, 32'hDEADBEEF);
    tick();
    check("wr_pulse_one", cpu_data_ok, 0);

    // Back-to-back read then write, request held, slave always ready
    axi.ARREADY = 1'b1;
    axi.RVALID  = 1'b1;
    axi.RLAST   = 1'b1;
    axi.RDATA   = 32'hA5A50001;
    axi.AWREADY = 1'b1;
    axi.WREADY  = 1'b1;
    axi.BVALID  = 1'b1;
    cpu_issue(1'b0, 32'h40, 32'h0, 4'hf);
    check("b2b_idle_ok", cpu_addr_ok, 1);
    tick();  // AR
    cpu_issue(1'b1, 32'h44, 32'hCAFEF00D, 4'hf);
    check("b2b_ar_ok", cpu_addr_ok, 0);
    check("b2b_ar_noaw", axi.AWVALID, 0);
    tick();  // R
    check("b2b_r_ok", cpu_addr_ok, 0);
    check("b2b_r_noaw", axi.AWVALID, 0);
    tick();  // DONE
    check("b2b_rd_done", cpu_data_ok, 1);
    check("b2b_rd_data", cpu_rdata, 32'hA5A50001);
    check("b2b_done_ok", cpu_addr_ok, 0);
    tick();  // IDLE, write accepted here
    check("b2b_idle2_ok", cpu_addr_ok, 1);
    check("b2b_idle2_noaw", axi.AWVALID, 0);
    tick();  // AW_W
    cpu_req = 1'b0;
    check("b2b_awvalid", axi.AWVALID, 1);
    check("b2b_wvalid", axi.WVALID, 1);
    check("b2b_no_ar", axi.ARVALID, 0);
    check("b2b_awaddr", axi.AWADDR, 32'h44);
    tick();  // B
    check("b2b_bready", axi.BREADY, 1);
    tick();  // DONE
    check("b2b_wr_done", cpu_data_ok, 1);
    tick();
    slave_idle();

    // Error responses; also a non-last read beat must be ignored
    cpu_issue(1'b0, 32'h50, 32'h0, 4'hf);
    axi.ARREADY = 1'b1;
    tick();  // AR
    cpu_req = 1'b0;
    tick();  // R
    axi.ARREADY = 1'b0;
    axi.RVALID  = 1'b1;
    axi.RLAST   = 1'b0;
    axi.RDATA   = 32'h00000BAD;
    tick();  // still R
    check("err_nonlast_ok", cpu_data_ok, 0);
    check("err_nonlast_rready", axi.RREADY, 1);
    axi.RLAST = 1'b1;
    axi.RRESP = 2'b10;
    axi.RDATA = 32'h11112222;
    tick();  // DONE
    slave_idle();
    check("err_rd_ok", cpu_data_ok, 1);
    check("err_rd_err", cpu_err, 1);
    check("err_rd_data", cpu_rdata, 32'h11112222);
    tick();
    check("err_rd_err_clr", cpu_err, 0);
    cpu_issue(1'b1, 32'h54, 32'h33334444, 4'hf);
    axi.AWREADY = 1'b1;
    axi.WREADY  = 1'b1;
    axi.BVALID  = 1'b1;
    axi.BRESP   = 2'b11;
    tick();  // AW_W
    cpu_req = 1'b0;
    tick();  // B
    tick();  // DONE
    check("err_wr_ok", cpu_data_ok, 1);
    check("err_wr_err", cpu_err, 1);
    check("err_wr_rdata_kept", cpu_rdata, 32'h11112222);
    slave_idle();
    tick();

    // ARREADY stall for 5 cycles while the CPU address moves
    cpu_issue(1'b0, 32'h60, 32'h0, 4'hf);
    tick();  // AR
    cpu_req     = 1'b0;
    cpu_address = 32'h99;
    for (int i = 0; i < 5; i++) begin
      check("stall_arvalid", axi.ARVALID, 1);
      check("stall_araddr", axi.ARADDR, 32'h60);
      tick();
    end
    check("stall_arvalid_end", axi.ARVALID, 1);
    axi.ARREADY = 1'b1;
    tick();  // R
    axi.ARREADY = 1'b0;
    check("stall_rready", axi.RREADY, 1);
    axi.RVALID = 1'b1;
    axi.RLAST  = 1'b1;
    axi.RDATA  = 32'h60606060;
    tick();  // DONE
    slave_idle();
    check("stall_ok", cpu_data_ok, 1);
    check("stall_rdata", cpu_rdata, 32'h60606060);
    tick();

    // Reset during AW_W
    cpu_issue(1'b1, 32'h70, 32'h77777777, 4'hf);
    tick();  // AW_W
    cpu_req = 1'b0;
    check("rstmid_awvalid", axi.AWVALID, 1);
    #2;
    ARESETn = 1'b0;
    #1;
    check("rstmid_awvalid_drop", axi.AWVALID, 0);
    check("rstmid_wvalid_drop", axi.WVALID, 0);
    check("rstmid_arvalid", axi.ARVALID, 0);
    check("rstmid_bready", axi.BREADY, 0);
    check("rstmid_addr_ok", cpu_addr_ok, 1);
    @(negedge ACLK);
    ARESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstmid_no_pulse", cpu_data_ok, 0);
      check("rstmid_idle", cpu_addr_ok, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/sram2axi_master.md
Name: sram2axi_master

Overview:
- Upstream neighbour of the AXI-to-SRAM-bus slave bridge.
- Converts the core's SRAM-style request bus (req/we/addr_ok/data_ok) into AXI3 single-beat master transactions.
- Its AW/W/B/AR/R channels connect directly, or through the interconnect, to the slave bridge.
- One outstanding transaction at a time, so response ordering and IDs are trivial.

Parameters:
- DATA_WIDTH, 32, data bus width (SRAM side and AXI side)
- ADDR_WIDTH, 32, address width
- ID_WIDTH, 4, AXI ID width
- STRB_WIDTH, DATA_WIDTH/8, byte-mask / WSTRB width
- MASTER_ID, 0, constant driven on AWID/WID/ARID

Ports:
- ACLK  in  1  clock, all state on rising edge
- ARESETn  in  1  asynchronous active-low reset
- cpu_req  in  1  request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_address  in  ADDR_WIDTH  byte address
- cpu_wdata  in  DATA_WIDTH  write data
- cpu_wmask  in  STRB_WIDTH  byte enables
- cpu_addr_ok  out  1  request accepted this cycle
- cpu_data_ok  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  read data, valid with cpu_data_ok
- cpu_err  out  1  error response, valid with cpu_data_ok
- AWADDR/AWLEN[3:0]/AWSIZE[2:0]/AWBURST[1:0]/AWID/AWVALID  out  write address channel
- AWREADY  in
- WDATA/WSTRB/WLAST/WID/WVALID  out  write data channel
- WREADY  in
- BID[ID_WIDTH]/BRESP[1:0]/BVALID  in  write response channel
- BREADY  out
- ARADDR/ARLEN/ARSIZE/ARBURST/ARID/ARVALID  out  read address channel
- ARREADY  in
- RDATA/RRESP/RLAST/RID/RVALID  in  read data channel
- RREADY  out

Behaviour:
- Clock is ACLK. Reset is ARESETn: asynchronous, active-low, one clock domain.
- Reset forces state IDLE and all registered outputs to 0: AWVALID, WVALID, ARVALID, BREADY, RREADY, cpu_data_ok, cpu_err, cpu_rdata, and the latched addr/data/mask.
- States and transitions:
  - IDLE: cpu_addr_ok = 1, combinational and only in IDLE. On cpu_req, latch address, wdata, wmask and we, then go to AR (we=0) or AW_W (we=1).
  - AR: ARVALID = 1, held with stable ARADDR until ARREADY, then go to R.
  - R: RREADY = 1. On RVALID && RLAST, capture RDATA into cpu_rdata, set err = (RRESP != 0), go to DONE. Beats with RLAST = 0 are accepted and discarded.
  - AW_W: AWVALID and WVALID both assert on entry. Each deasserts independently on its own handshake (AWVALID&&AWREADY, WVALID&&WREADY); handshakes may occur in the same or different cycles, in either order. When both are done, go to B.
  - B: BREADY = 1. On BVALID, err = (BRESP != 0), go to DONE.
  - DONE: cpu_data_ok = 1 and cpu_err = err for exactly one cycle, cpu_addr_ok = 0, then go to IDLE.
- cpu_rdata holds its value until the next read completes. For writes it is unchanged.
- Fixed AXI fields:
  - AWLEN = ARLEN = 0, AWBURST = ARBURST = 2'b01 (INCR).
  - AWSIZE = ARSIZE = log2(STRB_WIDTH), i.e. 3'b010 at 32-bit.
  - WLAST = WVALID.
  - AWID = WID = ARID = MASTER_ID.
  - WSTRB = latched mask; reads ignore the mask.
- BID and RID are not checked, since only one transaction is ever outstanding.
- Latency, with acceptance at cycle T and zero-wait slave:
  - Read: ARVALID at T+1, RREADY at T+2, cpu_data_ok at T+3.
  - Write: AW/W valid at T+1, BREADY at T+2, cpu_data_ok at T+3.
  - Next request is accepted at T+4 at the earliest.
- Valid signals never drop before their handshake, and address/data stay stable while valid (AXI rule).
- cpu_req while not IDLE is ignored (addr_ok = 0). The requester holds the request until addr_ok.
- A reset mid-transaction drops all valids and readies immediately. There is no completion pulse for the aborted request.

Test Plan:
- Read to 0x0000_0010, slave ARREADY=1, RVALID at T+2 with RDATA=0xDEADBEEF, RRESP=0 -> ARADDR=0x10, ARLEN=0, ARSIZE=2; cpu_data_ok single pulse at T+3 with cpu_rdata=0xDEADBEEF, cpu_err=0.
- Write 0x1234_5678 mask 4'b0011 to 0x20; AWREADY at T+3, WREADY at T+1 -> WVALID drops at T+2, AWVALID held to T+3 with stable AWADDR=0x20, WSTRB=0x3, WLAST=1; BREADY from T+4; BVALID at T+5 -> cpu_data_ok at T+6.
- Back-to-back read then write with cpu_req held high -> cpu_addr_ok only in IDLE; second request accepted the cycle after the first completion pulse, no overlap of AR and AW activity.
- Read returning RRESP=2'b10, then write returning BRESP=2'b11 -> cpu_err=1 with each cpu_data_ok; cpu_rdata updated on the read only.
- Slave stalls ARREADY 5 cycles, ARADDR changed at the CPU side -> ARVALID held continuously, ARADDR stays the latched value.
- ARESETn low during AW_W with AWVALID=1 -> all valids 0 asynchronously; after release, state IDLE, cpu_addr_ok=1, no cpu_data_ok pulse.
